lieat_ifu_bpu: RTL and testbench
================================

Name: lieat_ifu_bpu

Overview:
- Registered IFU branch predecode/predict stage, one instruction per cycle.
- Classifies each fetched instruction (bxx, jal, jalr, ecall, mret, fence.i) and computes its static prediction: BTFN for bxx, always-taken for jal, return-address-stack (RAS) for returns.
- Sits between the fetch buffer and the IFU redirect/IDU interface, with a valid/ready handshake on both sides.
- The EXU flush input discards in-flight state.

Parameters:
- XLEN, 32, data/PC width.
- RAS_DEPTH, 4, return-address-stack entries (power of two, >=2).
- BXX_MODE, 1, 0 = bxx always predicted not-taken; 1 = BTFN (backward taken, forward not-taken).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  EXU mispredict/trap flush
- in_valid  in  1  fetched instruction valid
- in_ready  out  1  stage can accept
- in_pc  in  XLEN  instruction PC
- in_inst  in  32  instruction word
- out_valid  out  1  predecoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  registered PC
- out_inst  out  32  registered instruction
- out_type  out  3  BR_* class
- out_pred_taken  out  1  predicted redirect
- out_pred_target  out  XLEN  predicted target (0 when not taken)
- out_unpred  out  1  jalr with no RAS prediction; IFU stalls until EXU resolves

Behaviour:
- Reset (async): out_valid=0, out_pc=0, out_inst=0, out_type=BR_NONE, out_pred_taken=0, out_pred_target=0, out_unpred=0, RAS ptr=0, RAS count=0. RAS data contents are don't-care.
- in_ready = ~flush & (~out_valid | out_ready), combinational.
- Accept = in_valid & in_ready. On accept, the output register loads next cycle with out_valid=1. Latency is 1 cycle.
- out_valid & ~out_ready: all out_* hold stable.
- Output drains without a new accept: out_valid clears.
- flush=1: out_valid clears next edge, no accept that cycle, RAS ptr/count unchanged (no repair).
- Classification matches the IFU decode opcodes: bxx=1100011, jal=1101111, jalr=1100111, fence.i=0001111 with funct3=001, ecall/mret=1110011 with funct3=000 and inst[31:20]=0x000/0x302. Anything else is BR_NONE.
- Immediates:
  - J-imm: {sext inst[31], inst[19:12], inst[20], inst[30:21], 0}
  - B-imm: {sext inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - Sums are modulo 2^XLEN.
- jal: taken, target = pc + J-imm.
- bxx:
  - BXX_MODE=1: taken iff inst[31]=1, target = pc + B-imm.
  - BXX_MODE=0: not taken.
- Link registers are x1 and x5. link(r) = (r==1 | r==5). rd=inst[11:7], rs1=inst[19:15].
- RAS action on accepted jal: push pc+4 if link(rd).
- RAS action on accepted jalr:
  - !link(rd) & !link(rs1): none, out_unpred=1.
  - !link(rd) & link(rs1): pop, predict target=top.
  - link(rd) & !link(rs1): push pc+4, out_unpred=1.
  - link(rd) & link(rs1) & rd!=rs1: pop then push pc+4, predict target=old top.
  - link(rd) & link(rs1) & rd==rs1: push only, out_unpred=1.
- Pop with count=0: no prediction (taken=0, target=0, out_unpred=1), ptr/count unchanged.
- Push:
  - Writes entry[ptr], then ptr = ptr+1 mod RAS_DEPTH.
  - count saturates at RAS_DEPTH.
  - At full, the oldest entry is overwritten (circular).
- Pop: top = entry[ptr-1], ptr decrements, count decrements.
- Pop+push same cycle: entry[ptr-1] is overwritten with pc+4; ptr and count unchanged (count=0 case is treated as push only).
- ecall, mret, fence.i: out_pred_taken=0; out_type flags the instruction so the IFU serialises.
- RAS updates only on accept, never on flush cycles.

Decomposition:
- Package lieat_bpu_pkg:
  - BR_NONE=0, BR_BXX=1, BR_JAL=2, BR_JALR=3, BR_ECALL=4, BR_MRET=5, BR_FENCEI=6
  - opcode constants
  - LINK_X1=1, LINK_X5=5
- Sub-module lieat_ifu_ras: parametrised circular stack with push/pop/top/empty, pop-then-push in one cycle, async reset of ptr/count.

Test Plan:
- Reset mid-stream, then in_inst=0x008000EF (jal x1,+8) at pc=0x1000 -> next cycle out_type=BR_JAL, taken=1, target=0x1008, RAS top=0x1004.
- Then jalr x0,0(x1)=0x00008067 at pc=0x2000 -> taken=1, target=0x1004, count back to 0. Repeating it -> out_unpred=1, taken=0.
- bxx beq x0,x0,-4 (0xFE000EE3) at pc=0x3000: BXX_MODE=1 -> target=0x2FFC, taken=1. Forward +8 -> taken=0. BXX_MODE=0 -> both taken=0.
- RAS_DEPTH=4, 5 calls from pc 0x100,0x200,…,0x500, then 5 returns -> targets 0x504,0x404,0x304,0x204, then the 5th has out_unpred=1 (0x104 overwritten).
- out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, outputs stable, no RAS change. Release -> the next instruction is accepted.
- flush asserted with in_valid=1 and a jal x1 pending -> no accept, out_valid=0 next cycle, RAS count unchanged.
- ecall 0x00000073 / mret 0x30200073 / fence.i 0x0000100F -> out_type 4/5/6, taken=0.

Source files
------------

// File: rtl/lieat_bpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_bpu_pkg
//  Description : Shared definitions for the IFU branch predecode/predict
//                stage: branch classes, opcode constants, link registers
//                and the link-register test.
//  Revision    : 1.0  initial release
// ============================================================================
package lieat_bpu_pkg;

    typedef enum logic [2:0] {
        BR_NONE   = 3'd0,
        BR_BXX    = 3'd1,
        BR_JAL    = 3'd2,
        BR_JALR   = 3'd3,
        BR_ECALL  = 3'd4,
        BR_MRET   = 3'd5,
        BR_FENCEI = 3'd6
    } br_type_e;

    localparam logic [6:0]  OPC_BXX      = 7'b1100011;
    localparam logic [6:0]  OPC_JAL      = 7'b1101111;
    localparam logic [6:0]  OPC_JALR     = 7'b1100111;
    localparam logic [6:0]  OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0]  F3_FENCEI    = 3'b001;
    localparam logic [2:0]  F3_PRIV      = 3'b000;

    localparam logic [11:0] SYS_ECALL    = 12'h000;
    localparam logic [11:0] SYS_MRET     = 12'h302;

    localparam logic [4:0]  LINK_X1      = 5'd1;
    localparam logic [4:0]  LINK_X5      = 5'd5;

    // x1/x5 are the ABI link registers used for call/return hinting.
    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lieat_ifu_bpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_ifu_bpu_if
//  Description : Handshake bundle around the predecode stage.
//                in_*  : fetch buffer -> stage (valid/ready, pc, inst)
//                out_* : stage -> IFU redirect / IDU (valid/ready plus the
//                        registered pc, inst, class and static prediction)
//                master modport = environment side, slave = the stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface lieat_ifu_bpu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [2:0]      out_type;
    logic            out_pred_taken;
    logic [XLEN-1:0] out_pred_target;
    logic            out_unpred;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_type,
               out_pred_taken, out_pred_target, out_unpred
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_type,
               out_pred_taken, out_pred_target, out_unpred
    );
endinterface
`default_nettype wire

// File: rtl/lieat_ifu_ras.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_ifu_ras
//  Description : Circular return-address stack.
//                push/push_data : write entry[ptr], advance ptr
//                pop            : drop entry[ptr-1]
//                push+pop       : overwrite entry[ptr-1] in place
//                top/empty      : current top entry and empty flag
//                A push at full silently overwrites the oldest entry.
//  Revision    : 1.0  initial release
// ============================================================================
module lieat_ifu_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  entry_q [RAS_DEPTH];

    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic [PTR_W-1:0] top_idx;

    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = entry_q[top_idx];
    assign empty   = (cnt_q == '0);

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !empty) begin
            // Return-then-call: replace the top, depth unchanged.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset: they are only observed when count > 0.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            entry_q[wr_idx] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lieat_ifu_bpu.sv
`default_nettype none
// ============================================================================
//  Module      : lieat_ifu_bpu
//  Description : Registered IFU branch predecode/predict stage. Classifies
//                one fetched instruction per cycle and attaches a static
//                prediction (BTFN / always-taken jal / RAS returns).
//                clock, reset : core clock, async active-high reset
//                flush        : EXU flush, drops the output entry
//                bus          : in_* handshake from fetch buffer,
//                               out_* handshake to IFU redirect / IDU
//  Revision    : 1.0  initial release
// ============================================================================
module lieat_ifu_bpu
    import lieat_bpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int BXX_MODE  = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    lieat_ifu_bpu_if.slave bus
);
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    br_type_e        cls;

    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] b_imm;
    logic [XLEN-1:0] link_pc;

    logic            in_ready;
    logic            accept;

    logic            want_push;
    logic            want_pop;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;

    logic            pred_taken;
    logic            pred_unpred;
    logic [XLEN-1:0] pred_target;

    logic            valid_q,  valid_d;
    logic [XLEN-1:0] pc_q,     pc_d;
    logic [31:0]     inst_q,   inst_d;
    br_type_e        type_q,   type_d;
    logic            taken_q,  taken_d;
    logic [XLEN-1:0] target_q, target_d;
    logic            unpred_q, unpred_d;

    assign inst    = bus.in_inst;
    assign pc      = bus.in_pc;
    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rd      = inst[11:7];
    assign rs1     = inst[19:15];

    assign j_imm   = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b_imm   = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign link_pc = pc + XLEN'(4);

    // A flush kills the accept so the RAS never sees wrong-path updates.
    assign in_ready = ~flush & (~valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        cls = BR_NONE;
        case (opcode)
            OPC_BXX:  cls = BR_BXX;
            OPC_JAL:  cls = BR_JAL;
            OPC_JALR: cls = BR_JALR;
            OPC_MISC_MEM: begin
                if (funct3 == F3_FENCEI) begin
                    cls = BR_FENCEI;
                end
            end
            OPC_SYSTEM: begin
                if (funct3 == F3_PRIV) begin
                    if (inst[31:20] == SYS_ECALL) begin
                        cls = BR_ECALL;
                    end else if (inst[31:20] == SYS_MRET) begin
                        cls = BR_MRET;
                    end
                end
            end
            default:  cls = BR_NONE;
        endcase
    end

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = '0;
        pred_unpred = 1'b0;
        want_push   = 1'b0;
        want_pop    = 1'b0;
        case (cls)
            BR_JAL: begin
                pred_taken  = 1'b1;
                pred_target = pc + j_imm;
                want_push   = is_link(rd);
            end
            BR_BXX: begin
                // Sign bit of the B-immediate marks a backward branch.
                if ((BXX_MODE != 0) && inst[31]) begin
                    pred_taken  = 1'b1;
                    pred_target = pc + b_imm;
                end
            end
            BR_JALR: begin
                // rd==rs1 with both links is a fresh call, not a return.
                want_push = is_link(rd);
                want_pop  = is_link(rs1) && !(is_link(rd) && (rd == rs1));
                if (want_pop && !ras_empty) begin
                    pred_taken  = 1'b1;
                    pred_target = ras_top;
                end else begin
                    pred_unpred = 1'b1;
                end
            end
            default: begin
                pred_taken = 1'b0;
            end
        endcase
    end

    lieat_ifu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (accept & want_push),
        .pop       (accept & want_pop),
        .push_data (link_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        type_d   = type_q;
        taken_d  = taken_q;
        target_d = target_q;
        unpred_d = unpred_q;
        if (accept) begin
            valid_d  = 1'b1;
            pc_d     = pc;
            inst_d   = inst;
            type_d   = cls;
            taken_d  = pred_taken;
            target_d = pred_target;
            unpred_d = pred_unpred;
        end else if (flush || bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            inst_q   <= '0;
            type_q   <= BR_NONE;
            taken_q  <= 1'b0;
            target_q <= '0;
            unpred_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            type_q   <= type_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            unpred_q <= unpred_d;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.out_valid       = valid_q;
    assign bus.out_pc          = pc_q;
    assign bus.out_inst        = inst_q;
    assign bus.out_type        = type_q;
    assign bus.out_pred_taken  = taken_q;
    assign bus.out_pred_target = target_q;
    assign bus.out_unpred      = unpred_q;

endmodule
`default_nettype wire

// File: tb/tb_lieat_ifu_bpu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_lieat_ifu_bpu
//  Description : Bench for lieat_ifu_bpu. Two instances (BXX_MODE 1 and 0)
//                share one stimulus stream; a queue-based model predicts
//                every output and is compared on each falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lieat_ifu_bpu;
    localparam int XLEN      = 32;
    localparam int RAS_DEPTH = 4;

    localparam logic [31:0] JAL_X1 = 32'h008000EF;  // jal x1, +8
    localparam logic [31:0] RET    = 32'h00008067;  // jalr x0, 0(x1)
    localparam logic [31:0] BEQ_BK = 32'hFE000EE3;  // beq x0,x0,-4
    localparam logic [31:0] BEQ_FW = 32'h00000463;  // beq x0,x0,+8

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;

    int n_pass  = 0;
    int n_total = 0;

    lieat_ifu_bpu_if #(.XLEN(XLEN)) bus1 ();
    lieat_ifu_bpu_if #(.XLEN(XLEN)) bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_pc     = in_pc;
    assign bus1.in_inst   = in_inst;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_pc     = in_pc;
    assign bus0.in_inst   = in_inst;
    assign bus0.out_ready = out_ready;

    lieat_ifu_bpu #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH), .BXX_MODE(1)) dut1 (
        .clock (clock), .reset (reset), .flush (flush), .bus (bus1)
    );
    lieat_ifu_bpu #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH), .BXX_MODE(0)) dut0 (
        .clock (clock), .reset (reset), .flush (flush), .bus (bus0)
    );

    initial forever #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;
    logic [2:0]  m_ty = '0;
    logic        m_tk [2];
    logic [31:0] m_tg [2];
    logic        m_un = 1'b0;
    logic [31:0] ras [$];

    function automatic logic [2:0] classify(input logic [31:0] w);
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [11:0] hi;
        op = w[6:0];
        f3 = w[14:12];
        hi = w[31:20];
        if (op == 7'b1100011) return 3'd1;
        if (op == 7'b1101111) return 3'd2;
        if (op == 7'b1100111) return 3'd3;
        if (op == 7'b0001111 && f3 == 3'b001) return 3'd6;
        if (op == 7'b1110011 && f3 == 3'b000 && hi == 12'h000) return 3'd4;
        if (op == 7'b1110011 && f3 == 3'b000 && hi == 12'h302) return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic is_lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] w);
        logic [20:0] raw;
        raw = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'($signed(raw));
    endfunction

    function automatic logic [31:0] bimm(input logic [31:0] w);
        logic [12:0] raw;
        raw = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        return 32'($signed(raw));
    endfunction

    task automatic ras_push(input logic [31:0] v);
        if (ras.size() == RAS_DEPTH) void'(ras.pop_front());
        ras.push_back(v);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_pc = '0; m_inst = '0; m_ty = '0; m_un = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_tk[k] = 1'b0;
            m_tg[k] = '0;
        end
        ras.delete();
    endtask

    task automatic model_step();
        logic [31:0] w, pc, lk;
        logic [4:0]  rd, rs1;
        bit          rdy, lr, wp;
        rdy = !flush && (!m_valid || out_ready);
        if (in_valid && rdy) begin
            w = in_inst; pc = in_pc; lk = pc + 32'd4;
            rd = w[11:7]; rs1 = w[19:15];
            m_valid = 1'b1; m_pc = pc; m_inst = w; m_ty = classify(w); m_un = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_tk[k] = 1'b0;
                m_tg[k] = '0;
            end
            if (m_ty == 3'd2) begin
                for (int k = 0; k < 2; k++) begin
                    m_tk[k] = 1'b1;
                    m_tg[k] = pc + jimm(w);
                end
                if (is_lnk(rd)) ras_push(lk);
            end else if (m_ty == 3'd1) begin
                if (w[31]) begin
                    m_tk[1] = 1'b1;
                    m_tg[1] = pc + bimm(w);
                end
            end else if (m_ty == 3'd3) begin
                lr = is_lnk(rd);
                wp = is_lnk(rs1) && !(lr && rd == rs1);
                if (wp && ras.size() > 0) begin
                    for (int k = 0; k < 2; k++) begin
                        m_tk[k] = 1'b1;
                        m_tg[k] = ras[ras.size()-1];
                    end
                    if (lr) ras[ras.size()-1] = lk;
                    else void'(ras.pop_back());
                end else begin
                    m_un = 1'b1;
                    if (lr) ras_push(lk);
                end
            end
        end else if (flush || out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cmp_dut(input int md, input logic rdy, input logic vld,
                           input logic [31:0] pc, input logic [31:0] w,
                           input logic [2:0] ty, input logic tk,
                           input logic [31:0] tg, input logic un);
        string p;
        p = (md == 1) ? "m1" : "m0";
        chk({p, ".in_ready"}, 32'(rdy), 32'(!flush && (!m_valid || out_ready)));
        chk({p, ".out_valid"}, 32'(vld), 32'(m_valid));
        if (m_valid) begin
            chk({p, ".out_pc"}, pc, m_pc);
            chk({p, ".out_inst"}, w, m_inst);
            chk({p, ".out_type"}, 32'(ty), 32'(m_ty));
            chk({p, ".pred_taken"}, 32'(tk), 32'(m_tk[md]));
            chk({p, ".pred_target"}, tg, m_tg[md]);
            chk({p, ".unpred"}, 32'(un), 32'(m_un));
        end
    endtask

    // Single compare process: check the registered state, then advance.
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            if (reset) model_reset();
            cmp_dut(1, bus1.in_ready, bus1.out_valid, bus1.out_pc, bus1.out_inst,
                    bus1.out_type, bus1.out_pred_taken, bus1.out_pred_target, bus1.out_unpred);
            cmp_dut(0, bus0.in_ready, bus0.out_valid, bus0.out_pc, bus0.out_inst,
                    bus0.out_type, bus0.out_pred_taken, bus0.out_pred_target, bus0.out_unpred);
            if (!reset) model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] pc, input logic [31:0] w, input logic ordy);
        @(posedge clock);
        #1;
        reset = r; flush = f; in_valid = v; in_pc = pc; in_inst = w; out_ready = ordy;
    endtask

    // One accepted instruction; outputs are then valid for literal checks.
    task automatic send(input logic [31:0] pc, input logic [31:0] w);
        drive(1'b0, 1'b0, 1'b1, pc, w, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
    endtask

    function automatic logic [4:0] pick_reg();
        int s;
        s = $urandom_range(0, 3);
        if (s == 0) return 5'd0;
        if (s == 1) return 5'd1;
        if (s == 2) return 5'd5;
        return 5'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          kind;
        r    = $urandom;
        kind = $urandom_range(0, 7);
        case (kind)
            0: return {r[31:12], pick_reg(), 7'b1101111};
            1: return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'b1100111};
            2: return {r[31:7], 7'b1100011};
            3: return 32'h00000073;
            4: return 32'h30200073;
            5: return {r[31:15], 3'b001, r[11:7], 7'b0001111};
            default: return r;
        endcase
    endfunction

    initial begin
        // Reset state
        drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        chk("reset.out_valid", 32'(bus1.out_valid), 32'd0);
        chk("reset.out_type", 32'(bus1.out_type), 32'd0);
        chk("reset.out_pc", bus1.out_pc, 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Fill the RAS, then reset mid-stream: it must come back empty.
        send(32'h40, JAL_X1);
        drive(1'b1, 1'b0, 1'b1, 32'h44, JAL_X1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Call / return / return on empty stack
        send(32'h1000, JAL_X1);
        chk("jal.type", 32'(bus1.out_type), 32'd2);
        chk("jal.taken", 32'(bus1.out_pred_taken), 32'd1);
        chk("jal.target", bus1.out_pred_target, 32'h1008);
        send(32'h2000, RET);
        chk("ret.taken", 32'(bus1.out_pred_taken), 32'd1);
        chk("ret.target", bus1.out_pred_target, 32'h1004);
        send(32'h2000, RET);
        chk("ret_empty.unpred", 32'(bus1.out_unpred), 32'd1);
        chk("ret_empty.taken", 32'(bus1.out_pred_taken), 32'd0);

        // BTFN vs always-not-taken
        send(32'h3000, BEQ_BK);
        chk("beq_bk.m1.taken", 32'(bus1.out_pred_taken), 32'd1);
        chk("beq_bk.m1.target", bus1.out_pred_target, 32'h2FFC);
        chk("beq_bk.m0.taken", 32'(bus0.out_pred_taken), 32'd0);
        chk("beq_bk.m0.target", bus0.out_pred_target, 32'h0);
        send(32'h3000, BEQ_FW);
        chk("beq_fw.m1.taken", 32'(bus1.out_pred_taken), 32'd0);
        chk("beq_fw.m0.taken", 32'(bus0.out_pred_taken), 32'd0);

        // Five nested calls overflow a four-entry stack
        for (int k = 1; k <= 5; k++) send(32'(k * 32'h100), JAL_X1);
        for (int k = 5; k >= 2; k--) begin
            send(32'h2000, RET);
            chk("ras_ret.target", bus1.out_pred_target, 32'(k * 32'h100 + 32'h4));
        end
        send(32'h2000, RET);
        chk("ras_ret5.unpred", 32'(bus1.out_unpred), 32'd1);

        // Downstream stall
        drive(1'b0, 1'b0, 1'b1, 32'h600, JAL_X1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h700, RET, 1'b0);
            #2;
            chk("stall.in_ready", 32'(bus1.in_ready), 32'd0);
            chk("stall.out_pc", bus1.out_pc, 32'h600);
        end
        send(32'h700, RET);
        chk("stall_rel.out_pc", bus1.out_pc, 32'h700);
        chk("stall_rel.target", bus1.out_pred_target, 32'h604);

        // Flush with a call pending: not accepted, RAS untouched
        drive(1'b0, 1'b1, 1'b1, 32'h900, JAL_X1, 1'b1);
        #2;
        chk("flush.in_ready", 32'(bus1.in_ready), 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        #2;
        chk("flush.out_valid", 32'(bus1.out_valid), 32'd0);
        send(32'hA00, RET);
        chk("flush_ret.unpred", 32'(bus1.out_unpred), 32'd1);

        // Serialising instructions
        send(32'hB00, 32'h00000073);
        chk("ecall.type", 32'(bus1.out_type), 32'd4);
        chk("ecall.taken", 32'(bus1.out_pred_taken), 32'd0);
        send(32'hB04, 32'h30200073);
        chk("mret.type", 32'(bus1.out_type), 32'd5);
        send(32'hB08, 32'h0000100F);
        chk("fencei.type", 32'(bus1.out_type), 32'd6);
        chk("fencei.taken", 32'(bus1.out_pred_taken), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom & 32'hFFFF_FFFC,
                  rand_inst(),
                  ($urandom_range(0, 3) != 0));
        end

        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
        repeat (3) @(posedge clock);
        #6;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
